bpi_flash_read_phy: RTL and testbench

//  Physical-pin stage of the BPI flash read path. Accepts mem-word addresses from the upstream read FSM.

---
 rtl/bpi_flash_read_phy.sv | 147 ++++++++++++++
 tb/tb_bpi_flash_read_phy.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bpi_flash_read_phy.sv
// Read-only BPI (parallel NOR) pin driver: asynchronous first access, page-mode follow-on
// words, and an address that auto-increments while the upstream request stays valid.
module bpi_flash_read_phy #(
  parameter int unsigned     C_MEM_WIDTH  = 16,
  parameter longint unsigned C_MEM_SIZE   = 64'd134217728,
  parameter int unsigned     C_PAGE_WORDS = 16,
  parameter int unsigned     C_T_ACC      = 10,
  parameter int unsigned     C_T_PACC     = 3,
  parameter int unsigned     C_T_CEH      = 2,
  localparam int unsigned    C_ADDR_WIDTH = $clog2(8 * C_MEM_SIZE / C_MEM_WIDTH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [C_ADDR_WIDTH-1:0] s_axis_addr_tdata,
  input  logic                    s_axis_addr_tvalid,
  output logic                    s_axis_addr_tready,
  output logic [C_MEM_WIDTH-1:0]  m_axis_data_tdata,
  output logic                    m_axis_data_tvalid,
  output logic                    busy,
  output logic [C_ADDR_WIDTH-1:0] bpi_a,
  input  logic [C_MEM_WIDTH-1:0]  bpi_dq_i,
  output logic [C_MEM_WIDTH-1:0]  bpi_dq_t,
  output logic                    bpi_ce_n,
  output logic                    bpi_oe_n,
  output logic                    bpi_we_n,
  output logic                    bpi_adv_n
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ACCESS   = 3'd1,
    ST_OUTPUT   = 3'd2,
    ST_CONTINUE = 3'd3,
    ST_RECOVER  = 3'd4
  } state_e;

  localparam int unsigned PG_W    = $clog2(C_PAGE_WORDS);
  localparam int unsigned CNT_MAX = (C_T_ACC > C_T_CEH) ? C_T_ACC : C_T_CEH;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] CNT_ACC  = CNT_W'(C_T_ACC - 1);
  localparam logic [CNT_W-1:0] CNT_PACC = CNT_W'(C_T_PACC - 1);
  localparam logic [CNT_W-1:0] CNT_CEH  = CNT_W'(C_T_CEH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e                  state_q, state_d;
  logic [C_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    ce_n_q, ce_n_d;
  logic                    oe_n_q, oe_n_d;
  logic                    valid_q, valid_d;
  logic [C_MEM_WIDTH-1:0]  data_q, data_d;
  logic                    busy_q;

  always_comb begin
    // NOTE: every next-state signal gets its hold value first, so no path through the case infers a latch.
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    ce_n_d  = ce_n_q;
    oe_n_d  = oe_n_q;
    data_d  = data_q;
    valid_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (s_axis_addr_tvalid) begin
          addr_d  = s_axis_addr_tdata;
          ce_n_d  = 1'b0;
          oe_n_d  = 1'b0;
          cnt_d   = CNT_ACC;
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_ONE;
        end else begin
          data_d  = bpi_dq_i;
          valid_d = 1'b1;
          state_d = ST_OUTPUT;
        end
      end
      ST_OUTPUT: begin
        addr_d  = addr_q + C_ADDR_WIDTH'(1);
        state_d = ST_CONTINUE;
      end
      ST_CONTINUE: begin
        // addr already points at the next word; offset 0 means a new page (including wrap to 0).
        if (s_axis_addr_tvalid) begin
          cnt_d   = (addr_q[PG_W-1:0] != '0) ? CNT_PACC : CNT_ACC;
          state_d = ST_ACCESS;
        end else begin
          ce_n_d  = 1'b1;
          oe_n_d  = 1'b1;
          cnt_d   = CNT_CEH;
          state_d = ST_RECOVER;
        end
      end
      ST_RECOVER: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - CNT_ONE;
      end
      default: begin
        ce_n_d  = 1'b1;
        oe_n_d  = 1'b1;
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // NOTE: reset is sampled on the clock edge only, and all state uses non-blocking assignments.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      ce_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      valid_q <= 1'b0;
      data_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      ce_n_q  <= ce_n_d;
      oe_n_q  <= oe_n_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      busy_q  <= (state_d != ST_IDLE);
    end
  end

  assign s_axis_addr_tready = valid_q;
  assign m_axis_data_tvalid = valid_q;
  assign m_axis_data_tdata  = data_q;
  assign busy               = busy_q;
  assign bpi_a              = addr_q;
  assign bpi_ce_n           = ce_n_q;
  assign bpi_oe_n           = oe_n_q;
  assign bpi_adv_n          = ce_n_q;
  assign bpi_we_n           = 1'b1;
  assign bpi_dq_t           = '1;

endmodule

// File: tb/tb_bpi_flash_read_phy.sv
// Bench for bpi_flash_read_phy: directed vector table, multi-cycle corner sequences and a
// randomized upstream checked against a cycle-timeline reference model.
module tb_bpi_flash_read_phy;

  localparam int unsigned T_ACC  = 4;
  localparam int unsigned T_PACC = 2;
  localparam int unsigned PAGE   = 4;
  localparam int unsigned T_CEH  = 2;
  localparam int unsigned AW     = 26;

  logic          clk;
  logic          rst_n;
  logic [AW-1:0] s_axis_addr_tdata;
  logic          s_axis_addr_tvalid;
  logic          s_axis_addr_tready;
  logic [15:0]   m_axis_data_tdata;
  logic          m_axis_data_tvalid;
  logic          busy;
  logic [AW-1:0] bpi_a;
  logic [15:0]   bpi_dq_i;
  logic [15:0]   bpi_dq_t;
  logic          bpi_ce_n;
  logic          bpi_oe_n;
  logic          bpi_we_n;
  logic          bpi_adv_n;

  bpi_flash_read_phy #(
    .C_MEM_WIDTH (16),
    .C_MEM_SIZE  (64'd134217728),
    .C_PAGE_WORDS(PAGE),
    .C_T_ACC     (T_ACC),
    .C_T_PACC    (T_PACC),
    .C_T_CEH     (T_CEH)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .s_axis_addr_tdata (s_axis_addr_tdata),
    .s_axis_addr_tvalid(s_axis_addr_tvalid),
    .s_axis_addr_tready(s_axis_addr_tready),
    .m_axis_data_tdata (m_axis_data_tdata),
    .m_axis_data_tvalid(m_axis_data_tvalid),
    .busy              (busy),
    .bpi_a             (bpi_a),
    .bpi_dq_i          (bpi_dq_i),
    .bpi_dq_t          (bpi_dq_t),
    .bpi_ce_n          (bpi_ce_n),
    .bpi_oe_n          (bpi_oe_n),
    .bpi_we_n          (bpi_we_n),
    .bpi_adv_n         (bpi_adv_n)
  );

  // Flash data model: each word reads back as its low address bits scrambled.
  assign bpi_dq_i = bpi_a[15:0] ^ 16'hA5A5;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: tracks the transaction as a timeline of edge numbers.
  int          cyc = 0;
  logic        m_busy = 1'b0;
  int          m_free = 0;
  int          m_pulse = 0;
  logic [AW-1:0] m_addr = '0;
  logic        exp_pulse = 1'b0;
  logic [15:0] exp_data = '0;
  logic [AW-1:0] exp_addr = '0;

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      exp_pulse = 1'b0;
      if (!rst_n) begin
        m_busy = 1'b0;
        m_free = cyc + 1;
      end else if (!m_busy) begin
        if (cyc >= m_free && s_axis_addr_tvalid) begin
          m_busy  = 1'b1;
          m_addr  = s_axis_addr_tdata;
          m_pulse = cyc + T_ACC;
        end
      end else if (cyc == m_pulse) begin
        exp_pulse = 1'b1;
        exp_addr  = m_addr;
        exp_data  = m_addr[15:0] ^ 16'hA5A5;
      end else if (cyc == m_pulse + 2) begin
        if (s_axis_addr_tvalid) begin
          m_addr  = m_addr + 1'b1;
          m_pulse = cyc + (((m_addr % PAGE) != 0) ? T_PACC : T_ACC);
        end else begin
          m_busy = 1'b0;
          m_free = cyc + T_CEH + 1;
        end
      end
    end
  end

  // Scoreboard: compares every pulse (expected or actual) against the model on the falling edge.
  logic          chk_on = 1'b0;
  int            npulse = 0;
  int            stable = 0;
  logic [AW-1:0] prev_a = '0;

  initial begin
    forever begin
      @(negedge clk);
      if (bpi_a === prev_a) stable++;
      else stable = 1;
      prev_a = bpi_a;
      if (chk_on && (exp_pulse || m_axis_data_tvalid === 1'b1)) begin
        check("mdl_pulse", m_axis_data_tvalid, exp_pulse);
        check("mdl_ready_eq_valid", s_axis_addr_tready, m_axis_data_tvalid);
        if (exp_pulse) begin
          check("mdl_data", m_axis_data_tdata, exp_data);
          check("mdl_addr", bpi_a, exp_addr);
          check("mdl_ce_low", {bpi_ce_n, bpi_oe_n}, 2'b00);
          check("mdl_addr_hold", stable > T_PACC, 1'b1);
        end
        npulse++;
      end
    end
  end

  typedef struct {
    logic [AW-1:0] addr;
    logic [15:0]   data;
    int            lat;
  } vec_t;

  vec_t          vecs[6];
  int            pe[8];
  logic [15:0]   pd[8];
  logic [AW-1:0] pa[8];
  int            acc_edge;
  int            ceh;
  int            hi;
  int            guard;
  int            n0;
  logic          seen;
  logic [AW-1:0] ra;

  // Issues one request from idle and holds it until n words have pulsed, then drops it.
  task automatic burst(input logic [AW-1:0] a, input int n);
    int got = 0;
    int g = 0;
    @(negedge clk);
    s_axis_addr_tvalid = 1'b1;
    s_axis_addr_tdata  = a;
    acc_edge = cyc + 1;
    while (got < n && g < 200) begin
      @(posedge clk);
      #1;
      g++;
      if (m_axis_data_tvalid) begin
        pe[got] = cyc;
        pd[got] = m_axis_data_tdata;
        pa[got] = bpi_a;
        got++;
        if (got == n) s_axis_addr_tvalid = 1'b0;
      end
    end
    s_axis_addr_tvalid = 1'b0;
    check("burst_word_count", got, n);
  endtask

  task automatic wait_idle(output int ce_hi);
    int g = 0;
    ce_hi = 0;
    do begin
      @(posedge clk);
      #1;
      g++;
      if (bpi_ce_n) ce_hi++;
    end while (busy && g < 100);
    check("idle_reached", busy, 1'b0);
  endtask

  initial begin
    vecs[0] = '{addr: 26'h0000010, data: 16'hA5B5, lat: 4};
    vecs[1] = '{addr: 26'h0000000, data: 16'hA5A5, lat: 4};
    vecs[2] = '{addr: 26'h0001234, data: 16'hB791, lat: 4};
    vecs[3] = '{addr: 26'h3FFFFFF, data: 16'h5A5A, lat: 4};
    vecs[4] = '{addr: 26'h000ABCD, data: 16'h0E68, lat: 4};
    vecs[5] = '{addr: 26'h00000FF, data: 16'hA55A, lat: 4};

    rst_n = 1'b0;
    s_axis_addr_tvalid = 1'b0;
    s_axis_addr_tdata  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ce_n", bpi_ce_n, 1'b1);
    check("rst_oe_n", bpi_oe_n, 1'b1);
    check("rst_we_n", bpi_we_n, 1'b1);
    check("rst_adv_n", bpi_adv_n, 1'b1);
    check("rst_bpi_a", bpi_a, '0);
    check("rst_dq_t", bpi_dq_t, 16'hFFFF);
    check("rst_tvalid", m_axis_data_tvalid, 1'b0);
    check("rst_tready", s_axis_addr_tready, 1'b0);
    check("rst_tdata", m_axis_data_tdata, 16'h0000);
    check("rst_busy", busy, 1'b0);
    @(negedge clk);
    rst_n  = 1'b1;
    chk_on = 1'b1;

    // Single-word reads from the vector table.
    for (int i = 0; i < 6; i++) begin
      burst(vecs[i].addr, 1);
      check("tbl_data", pd[0], vecs[i].data);
      check("tbl_latency", pe[0] - acc_edge, vecs[i].lat);
      wait_idle(ceh);
      check("tbl_ce_high_after", ceh >= 2, 1'b1);
      check("tbl_adv_follows_ce", bpi_adv_n, bpi_ce_n);
    end

    // Burst across a page boundary.
    burst(26'h0000002, 4);
    for (int i = 0; i < 4; i++) check("burst_data", pd[i], 16'(16'h0002 + i) ^ 16'hA5A5);
    check("burst_first_lat", pe[0] - acc_edge, T_ACC);
    check("burst_gap0", pe[1] - pe[0], 4);
    check("burst_gap1", pe[2] - pe[1], 6);
    check("burst_gap2", pe[3] - pe[2], 4);
    wait_idle(ceh);

    // Address wrap at the top of the array counts as a page crossing.
    burst(26'h3FFFFFF, 2);
    check("wrap_data0", pd[0], 16'h5A5A);
    check("wrap_data1", pd[1], 16'hA5A5);
    check("wrap_addr1", pa[1], '0);
    check("wrap_gap", pe[1] - pe[0], T_ACC + 2);
    wait_idle(ceh);

    // Reset while the first access is in flight.
    @(negedge clk);
    s_axis_addr_tvalid = 1'b1;
    s_axis_addr_tdata  = 26'h0000030;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    s_axis_addr_tvalid = 1'b0;
    @(posedge clk);
    #1;
    check("abort_ce_oe", {bpi_ce_n, bpi_oe_n}, 2'b11);
    check("abort_valid_ready", {m_axis_data_tvalid, s_axis_addr_tready}, 2'b00);
    check("abort_busy", busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (m_axis_data_tvalid) seen = 1'b1;
    end
    check("abort_no_pulse", seen, 1'b0);
    burst(26'h0000077, 1);
    check("abort_next_data", pd[0], 16'hA5D2);
    check("abort_next_lat", pe[0] - acc_edge, T_ACC);
    wait_idle(ceh);

    // Request re-raised during recovery waits for idle.
    burst(26'h0000020, 1);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rr_ce_rose", bpi_ce_n, 1'b1);
    @(negedge clk);
    s_axis_addr_tvalid = 1'b1;
    s_axis_addr_tdata  = 26'h0000040;
    hi = 1;
    guard = 0;
    do begin
      @(posedge clk);
      #1;
      guard++;
      if (bpi_ce_n) hi++;
    end while (bpi_ce_n && guard < 20);
    check("rr_ce_high_cycles", hi, T_CEH + 1);
    check("rr_addr", bpi_a, 26'h0000040);
    n0 = cyc;
    guard = 0;
    do begin
      @(posedge clk);
      #1;
      guard++;
    end while (!m_axis_data_tvalid && guard < 50);
    s_axis_addr_tvalid = 1'b0;
    check("rr_data", m_axis_data_tdata, 16'hA5E5);
    check("rr_latency", cyc - n0, T_ACC);
    wait_idle(ceh);

    // Randomized upstream: bursts of random length, random drops, boundary-heavy addresses.
    n0 = npulse;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (!s_axis_addr_tvalid) begin
        if ($urandom_range(0, 3) == 0) begin
          case ($urandom_range(0, 3))
            0: ra = 26'($urandom);
            1: ra = 26'h3FFFFFF - 26'($urandom_range(0, 3));
            2: ra = 26'($urandom) | 26'h3;
            default: ra = 26'($urandom_range(0, 31));
          endcase
          s_axis_addr_tdata  = ra;
          s_axis_addr_tvalid = 1'b1;
        end else begin
          s_axis_addr_tdata = 26'($urandom);
        end
      end else if ($urandom_range(0, 9) == 0) begin
        s_axis_addr_tvalid = 1'b0;
      end
    end
    @(negedge clk);
    s_axis_addr_tvalid = 1'b0;
    wait_idle(ceh);
    check("rnd_activity", (npulse - n0) > 100, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
